// File: rtl/pipe_div_seq_pkg.sv
// Shared definitions for the multi-cycle divide sequencer: default widths,
// FSM state encoding and the div/divu funct codes the control unit decodes.
package pipe_div_seq_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;

    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/pipe_div_seq_div_step.sv
// One restoring shift-subtract step. The partial remainder is shifted left by
// one bit with the next dividend bit, and the divisor is subtracted at WIDTH+1
// bits. A non-negative difference yields quotient bit 1 and replaces the
// remainder; otherwise the shifted value is kept (restored).
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    assign partial = {rem_in, bit_in};
    assign diff    = partial - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/pipe_div_seq.sv
// Multi-cycle signed/unsigned divide sequencer for the EXE stage.
// Operands are made positive, divided with one restoring step per cycle,
// and the signs are fixed up before the result is presented with done.
// Optional feature macro: PIPE_DIV_DZ_EN (early divide-by-zero detection with
// dz flag). Without it a zero divisor runs the full sequence and returns
// q = all-ones, r = dividend, and dz stays 0.
module pipe_div_seq
    import pipe_div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    div_state_t state;
    div_state_t state_next;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic             dvs_zero;
    logic             last_step;
`ifndef PIPE_DIV_DZ_EN
    logic [WIDTH-1:0] dividend_raw;
`endif

    assign dvs_zero  = (dvs == '0);
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // quo doubles as the dividend shift register: its top bit feeds the step
    // while quotient bits are shifted in at the bottom
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (quo[WIDTH-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next-state logic; cancel overrides everything, including a new start
    always_comb begin
        state_next = state;
        if (cancel) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state_next = S_PREP;
`ifdef PIPE_DIV_DZ_EN
                S_PREP: state_next = dvs_zero ? S_DONE : S_RUN;
`else
                S_PREP: state_next = S_RUN;
`endif
                S_RUN:  if (last_step) state_next = S_FIX;
                S_FIX:  state_next = S_DONE;
                S_DONE: state_next = start ? S_PREP : S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state; stall also covers the issue cycle
    always_comb begin
        stall = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_IDLE: stall = start;
            S_PREP, S_RUN, S_FIX: begin
                stall = 1'b1;
                busy  = 1'b1;
            end
            S_DONE: begin
                stall = start;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

`ifndef PIPE_DIV_DZ_EN
    assign dz = 1'b0;
`endif

    // Datapath: operand capture, iteration, sign fix-up; frozen while cancel is high
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            q     <= '0;
            r     <= '0;
`ifdef PIPE_DIV_DZ_EN
            dz    <= 1'b0;
`else
            dividend_raw <= '0;
`endif
        end else if (!cancel) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        quo   <= (sign && dividend[WIDTH-1]) ? -dividend : dividend;
                        dvs   <= (sign && divisor[WIDTH-1]) ? -divisor : divisor;
                        neg_q <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r <= sign & dividend[WIDTH-1];
`ifndef PIPE_DIV_DZ_EN
                        dividend_raw <= dividend;
`endif
                    end
                end
                S_PREP: begin
                    cnt <= '0;
                    rem <= '0;
`ifdef PIPE_DIV_DZ_EN
                    if (dvs_zero) begin
                        q  <= '0;
                        r  <= '0;
                        dz <= 1'b1;
                    end
`endif
                end
                S_RUN: begin
                    rem <= step_rem;
                    quo <= {quo[WIDTH-2:0], step_bit};
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIX: begin
`ifdef PIPE_DIV_DZ_EN
                    dz <= 1'b0;
                    q  <= neg_q ? -quo : quo;
                    r  <= neg_r ? -rem : rem;
`else
                    if (dvs_zero) begin
                        q <= '1;
                        r <= dividend_raw;
                    end else begin
                        q <= neg_q ? -quo : quo;
                        r <= neg_r ? -rem : rem;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_div_seq.sv
// Self-checking bench for pipe_div_seq. A reference model based on 64-bit
// integer division predicts stall/busy/done/q/r/dz every cycle; directed
// operations pin the model with hand-computed results. Honours PIPE_DIV_DZ_EN.
module tb_pipe_div_seq;

    localparam int W   = 32;
    localparam int LAT = 34;
`ifdef PIPE_DIV_DZ_EN
    localparam int          DZ_LAT = 1;
    localparam logic [31:0] DZ_Q   = 32'h0;
    localparam logic [31:0] DZ_R   = 32'h0;
    localparam logic        DZ_F   = 1'b1;
`else
    localparam int          DZ_LAT = 34;
    localparam logic [31:0] DZ_Q   = 32'hFFFF_FFFF;
    localparam logic [31:0] DZ_R   = 32'h5;
    localparam logic        DZ_F   = 1'b0;
`endif

    logic         clock;
    logic         resetn;
    logic         start;
    logic         sign;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         cancel;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // reference model state
    bit          m_active;
    bit          m_done;
    int          m_left;
    logic [31:0] m_q, m_r;
    logic        m_dz;
    logic [31:0] p_q, p_r;
    logic        p_dz;
    logic [31:0] c_q, c_r;
    logic        c_dz;
    int          c_lat;

    pipe_div_seq dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .sign     (sign),
        .dividend (dividend),
        .divisor  (divisor),
        .cancel   (cancel),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .dz       (dz)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void refDiv(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] qe, output logic [31:0] re,
                                   output logic dze, output int lat);
        longint sa;
        longint sb;
        if (b == 32'h0) begin
            qe  = DZ_Q;
            re  = (DZ_F) ? 32'h0 : a;
            dze = DZ_F;
            lat = DZ_LAT;
        end else begin
            sa  = sg ? longint'($signed(a)) : longint'({32'd0, a});
            sb  = sg ? longint'($signed(b)) : longint'({32'd0, b});
            qe  = 32'(sa / sb);
            re  = 32'(sa % sb);
            dze = 1'b0;
            lat = LAT;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit sg, input logic [31:0] a,
                                 input logic [31:0] b, input bit c);
        @(posedge clock);
        #2;
        start    = s;
        sign     = sg;
        dividend = a;
        divisor  = b;
        cancel   = c;
    endtask

    always_comb refDiv(sign, dividend, divisor, c_q, c_r, c_dz, c_lat);

    // model: an accepted op finishes a fixed number of edges later; cancel drops it
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_left   <= 0;
            m_q      <= '0;
            m_r      <= '0;
            m_dz     <= 1'b0;
            p_q      <= '0;
            p_r      <= '0;
            p_dz     <= 1'b0;
        end else if (cancel) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
        end else if (m_active) begin
            if (m_left == 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
                m_q      <= p_q;
                m_r      <= p_r;
                m_dz     <= p_dz;
            end else begin
                m_left <= m_left - 1;
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_active <= 1'b1;
                m_left   <= c_lat;
                p_q      <= c_q;
                p_r      <= c_r;
                p_dz     <= c_dz;
            end
        end
    end

    // compare every output against the model on each falling edge
    always @(negedge clock) begin
        if (check_en) begin
            checkOutput("stall", 32'(stall), 32'(m_active | start));
            checkOutput("busy",  32'(busy),  32'(m_active));
            checkOutput("done",  32'(done),  32'(m_done));
            checkOutput("q",     q,          m_q);
            checkOutput("r",     r,          m_r);
            checkOutput("dz",    32'(dz),    32'(m_dz));
        end
    end

    task automatic runOp(input string name, input bit sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz, input int elat);
        int  n;
        bit  seen;
        applyStimulus(1'b1, sg, a, b, 1'b0);
        applyStimulus(1'b0, sg, a, b, 1'b0);
        n    = 0;
        seen = 1'b0;
        while (n < 100 && !seen) begin
            @(negedge clock);
            if (done) seen = 1'b1;
            else      n++;
        end
        checkOutput({name, " latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(elat));
        checkOutput({name, " q"},  q,       eq);
        checkOutput({name, " r"},  r,       er);
        checkOutput({name, " dz"}, 32'(dz), 32'(edz));
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] tq, tr;
        logic        tdz;
        int          tlat;
        int          gap;
        bit          seen;

        resetn   = 1'b0;
        start    = 1'b0;
        sign     = 1'b0;
        dividend = '0;
        divisor  = '0;
        cancel   = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        checkOutput("reset busy",  32'(busy),  32'h0);
        checkOutput("reset done",  32'(done),  32'h0);
        checkOutput("reset stall", 32'(stall), 32'h0);
        checkOutput("reset q",     q,          32'h0);
        checkOutput("reset r",     r,          32'h0);
        checkOutput("reset dz",    32'(dz),    32'h0);
        resetn   = 1'b1;
        check_en = 1'b1;

        // pin the reference model with hand-computed values
        refDiv(1'b1, 32'hFFFF_FFF9, 32'h2, tq, tr, tdz, tlat);
        checkOutput("model -7/2 q", tq, 32'hFFFF_FFFD);
        checkOutput("model -7/2 r", tr, 32'hFFFF_FFFF);
        refDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, tq, tr, tdz, tlat);
        checkOutput("model ovf q", tq, 32'h8000_0000);
        checkOutput("model ovf r", tr, 32'h0);

        runOp("divu 7/2",  1'b0, 32'd7,          32'd2,          32'd3,          32'd1,          1'b0, LAT);
        runOp("div -7/2",  1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, LAT);
        runOp("div 7/-2",  1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, LAT);
        runOp("div ovf",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          1'b0, LAT);
        runOp("divu big",  1'b0, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'd15,         1'b0, LAT);
        runOp("divu 5/0",  1'b0, 32'd5,          32'd0,          DZ_Q,           DZ_R,           DZ_F, DZ_LAT);

        // cancel during cycle 10 of divu 100/3: nothing completes, results hold
        applyStimulus(1'b1, 1'b0, 32'd100, 32'd3, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 32'd100, 32'd3, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd100, 32'd3, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd100, 32'd3, 1'b0);
        @(negedge clock);
        checkOutput("cancel busy",  32'(busy),  32'h0);
        checkOutput("cancel stall", 32'(stall), 32'h0);
        checkOutput("cancel q",     q,          DZ_Q);
        checkOutput("cancel r",     r,          DZ_R);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        checkOutput("cancel no done", 32'(seen), 32'h0);

        // back-to-back: second start issued during the DONE cycle of the first
        applyStimulus(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
        repeat (34) applyStimulus(1'b0, 1'b0, 32'd100, 32'd7, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd9, 32'd4, 1'b0);
        @(negedge clock);
        checkOutput("b2b first done", 32'(done), 32'h1);
        checkOutput("b2b first q",    q,         32'd14);
        checkOutput("b2b first r",    r,         32'd2);
        applyStimulus(1'b0, 1'b0, 32'd9, 32'd4, 1'b0);
        gap  = 0;
        seen = 1'b0;
        while (gap < 100 && !seen) begin
            @(negedge clock);
            gap++;
            if (done) seen = 1'b1;
        end
        checkOutput("b2b gap", seen ? 32'(gap) : 32'hFFFF_FFFF, 32'd35);
        checkOutput("b2b second q", q, 32'd2);
        checkOutput("b2b second r", r, 32'd1);

        // random traffic, including starts while busy and occasional cancels
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                          pickOperand(), pickOperand(), $urandom_range(0, 99) == 0);
        end
        repeat (40) applyStimulus(1'b0, 1'b0, 32'h0, 32'h1, 1'b0);
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
